// File: rtl/pkt_wr_pkg.sv
// Shared types, constants and helpers for the packet write scheduler.
package pkt_wr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_COMMIT,
    S_ERR
  } sched_state_t;

  // Packets are stored on 4-byte boundaries.
  // One alignment unit stays unused so a full ring never looks empty.
  localparam int PKT_ALIGN = 4;

  // Control word layout: {packet count, descriptor length}.
  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_LEN_W   = 16;
  localparam int CTRL_CNT_LSB = 16;
  localparam int CTRL_CNT_W   = 16;

  // Round a byte length up to the next alignment unit.
  function automatic logic [31:0] round4(input logic [CTRL_LEN_W-1:0] len);
    logic [31:0] l;
    l = {{(32-CTRL_LEN_W){1'b0}}, len};
    return (l + 32'(PKT_ALIGN - 1)) & ~32'(PKT_ALIGN - 1);
  endfunction

endpackage

// File: rtl/pkt_wr_sched_if.sv
// Descriptor handshake plus the wr_ctrl command bus.
interface pkt_wr_sched_if;
  import pkt_wr_pkg::*;

  logic                  desc_valid;
  logic [CTRL_LEN_W-1:0] desc_len;
  logic                  desc_ready;
  logic [31:0]           host_rd_ptr;
  logic                  wr_ctrl;
  logic [31:0]           control;
  logic [31:0]           pkt_begin;
  logic [31:0]           pkt_end;
  logic [31:0]           write_address;
  logic                  wr_ctrl_rdy;

  // Scheduler side.
  modport master (
    input  desc_valid, desc_len, host_rd_ptr, wr_ctrl_rdy,
    output desc_ready, wr_ctrl, control, pkt_begin, pkt_end, write_address
  );

  // Capture / host / wr_ctrl side.
  modport slave (
    output desc_valid, desc_len, host_rd_ptr, wr_ctrl_rdy,
    input  desc_ready, wr_ctrl, control, pkt_begin, pkt_end, write_address
  );
endinterface

// File: rtl/ring_space_calc.sv
// Placement of one packet in the ring: start offset, wrap decision and
// whether the host has freed enough room (including the skipped tail pad).
module ring_space_calc
  import pkt_wr_pkg::*;
#(
  parameter int unsigned BUF_SIZE = 32'h10000
) (
  input  logic [31:0] wr_ptr,
  input  logic [31:0] host_rd_ptr,
  input  logic [31:0] len_w,
  output logic [31:0] start,
  output logic        wrap,
  output logic        fits
);

  localparam logic [32:0] SIZE = 33'(BUF_SIZE);
  localparam logic [31:0] MASK = 32'(BUF_SIZE - 1);

  logic [31:0] used;
  logic [32:0] need;

  // need <= free, with free = SIZE - ALIGN - used, rewritten as a sum so
  // a bogus host pointer can never underflow the comparison.
  always_comb begin
    used  = (wr_ptr - host_rd_ptr) & MASK;
    wrap  = ({1'b0, wr_ptr} + {1'b0, len_w}) > SIZE;
    start = wrap ? 32'd0 : wr_ptr;
    need  = wrap ? (SIZE - {1'b0, wr_ptr}) + {1'b0, len_w} : {1'b0, len_w};
    fits  = (need + {1'b0, used} + 33'(PKT_ALIGN)) <= SIZE;
  end

endmodule

// File: rtl/pkt_wr_sched.sv
// Packet write scheduler: places each accepted descriptor in the capture
// ring, drives one wr_ctrl burst per packet and commits the write pointer.
module pkt_wr_sched
  import pkt_wr_pkg::*;
#(
  parameter logic [31:0] BUF_BASE = 32'h8000,
  parameter int unsigned BUF_SIZE = 32'h10000,
  parameter int unsigned MAX_PKT  = 2048,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic           clk,
  input  logic           reset,
  pkt_wr_sched_if.master bus,
  output logic [31:0]    wr_ptr,
  output logic [31:0]    pkt_cnt,
  output logic [31:0]    wrap_cnt,
  output logic           full,
  output logic           pkt_done,
  output logic           err_oversize,
  output logic           err_timeout
);

  localparam logic [31:0] RING_MASK = 32'(BUF_SIZE - 1);
  localparam logic [31:0] WD_LAST   = 32'(TIMEOUT - 1);

  sched_state_t          state_reg, state_next;
  logic [CTRL_LEN_W-1:0] len_raw_reg;
  logic [31:0]           len_w_reg, start_reg, wd_reg;
  logic                  wrapped_reg;
  logic [31:0]           control_reg, pkt_end_reg, write_address_reg;
  logic [31:0]           wr_ptr_reg, pkt_cnt_reg, wrap_cnt_reg;
  logic                  err_oversize_reg, err_timeout_reg;

  logic [31:0] calc_start, control_next;
  logic        calc_wrap, calc_fits;
  logic        desc_fire, desc_legal, wd_expired, do_commit;

  ring_space_calc #(.BUF_SIZE(BUF_SIZE)) u_space (
    .wr_ptr      (wr_ptr_reg),
    .host_rd_ptr (bus.host_rd_ptr),
    .len_w       (len_w_reg),
    .start       (calc_start),
    .wrap        (calc_wrap),
    .fits        (calc_fits)
  );

  assign desc_fire  = (state_reg == S_IDLE) && bus.desc_valid;
  assign desc_legal = (bus.desc_len != '0) &&
                      ({{(32-CTRL_LEN_W){1'b0}}, bus.desc_len} <= 32'(MAX_PKT));
  assign wd_expired = (wd_reg == WD_LAST);
  assign do_commit  = (state_reg == S_WAIT) && (state_next == S_COMMIT);

  // Next-state and per-state output decode.
  always_comb begin
    state_next     = state_reg;
    bus.desc_ready = 1'b0;
    bus.wr_ctrl    = 1'b0;
    full           = 1'b0;
    pkt_done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        bus.desc_ready = 1'b1;
        if (desc_fire && desc_legal) state_next = S_CHECK;
      end
      S_CHECK: begin
        full = !calc_fits;
        if (calc_fits) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.wr_ctrl = 1'b1;
        if (wd_expired)            state_next = S_ERR;
        else if (!bus.wr_ctrl_rdy) state_next = S_WAIT;
      end
      S_WAIT: begin
        bus.wr_ctrl = 1'b1;
        if (wd_expired)           state_next = S_ERR;
        else if (bus.wr_ctrl_rdy) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        pkt_done   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_ERR;
    endcase
  end

  // Control word for the packet about to be issued.
  always_comb begin
    control_next = '0;
    control_next[CTRL_CNT_LSB +: CTRL_CNT_W] = pkt_cnt_reg[CTRL_CNT_W-1:0];
    control_next[CTRL_LEN_LSB +: CTRL_LEN_W] = len_raw_reg;
  end

  // State register, descriptor latch, watchdog, arguments and commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_IDLE;
      len_raw_reg       <= '0;
      len_w_reg         <= '0;
      start_reg         <= '0;
      wrapped_reg       <= 1'b0;
      wd_reg            <= '0;
      control_reg       <= '0;
      pkt_end_reg       <= '0;
      write_address_reg <= '0;
      wr_ptr_reg        <= '0;
      pkt_cnt_reg       <= '0;
      wrap_cnt_reg      <= '0;
      err_oversize_reg  <= 1'b0;
      err_timeout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (desc_fire) begin
        len_raw_reg <= bus.desc_len;
        len_w_reg   <= round4(bus.desc_len);
        if (bus.desc_len != '0 && !desc_legal) err_oversize_reg <= 1'b1;
      end
      if (state_reg == S_ISSUE || state_reg == S_WAIT) wd_reg <= wd_reg + 32'd1;
      else                                             wd_reg <= '0;
      if (state_reg == S_CHECK && calc_fits) begin
        start_reg         <= calc_start;
        wrapped_reg       <= calc_wrap;
        control_reg       <= control_next;
        pkt_end_reg       <= len_w_reg;
        write_address_reg <= BUF_BASE + calc_start;
      end
      if (do_commit) begin
        wr_ptr_reg   <= (start_reg + len_w_reg) & RING_MASK;
        pkt_cnt_reg  <= pkt_cnt_reg + 32'd1;
        wrap_cnt_reg <= wrap_cnt_reg + {31'd0, wrapped_reg};
      end
      if (state_next == S_ERR) err_timeout_reg <= 1'b1;
    end
  end

  assign bus.control       = control_reg;
  assign bus.pkt_begin     = 32'd0;
  assign bus.pkt_end       = pkt_end_reg;
  assign bus.write_address = write_address_reg;
  assign wr_ptr            = wr_ptr_reg;
  assign pkt_cnt           = pkt_cnt_reg;
  assign wrap_cnt          = wrap_cnt_reg;
  assign err_oversize      = err_oversize_reg;
  assign err_timeout       = err_timeout_reg;

endmodule

// File: tb/tb_pkt_wr_sched.sv
// Self-checking bench for pkt_wr_sched (ring of 256 bytes, watchdog 16).
module tb_pkt_wr_sched;

  localparam int RING = 256;
  localparam int TMO  = 16;
  localparam int HIGH = 10;  // wr_ctrl high cycles per burst with the rdy model

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] wr_ptr, pkt_cnt, wrap_cnt;
  logic        full, pkt_done, err_oversize, err_timeout;

  pkt_wr_sched_if bus ();

  pkt_wr_sched #(
    .BUF_BASE (32'h8000),
    .BUF_SIZE (RING),
    .MAX_PKT  (2048),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .wr_ptr       (wr_ptr),
    .pkt_cnt      (pkt_cnt),
    .wrap_cnt     (wrap_cnt),
    .full         (full),
    .pkt_done     (pkt_done),
    .err_oversize (err_oversize),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: committed values plus the packet in flight.
  int          m_wr_ptr, m_pkt_cnt, m_wrap_cnt, m_len_w, n_wr_ptr, n_wrap;
  bit          m_err_o, m_err_t, prev_fit, stuck;
  int          phase, iss;  // 0 idle, 1 placing, 2 issued, 3 error
  logic [31:0] x_ctrl, x_end, x_addr;
  bit          e_wc, e_pd, e_full, e_dr, done_now, cur_fit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {31'd0, act}, {31'd0, req});
  endtask

  function automatic bit model_fits(int wp, int rd, int lw);
    int used, free, need;
    used = ((wp - rd) % RING + RING) % RING;
    free = RING - 4 - used;
    need = (wp + lw > RING) ? (RING - wp) + lw : lw;
    return need <= free;
  endfunction

  // wr_ctrl_rdy model: low one cycle after wr_ctrl rises, high 8 cycles later.
  initial begin
    logic w, r, w_prev;
    int   cnt;
    bus.wr_ctrl_rdy = 1'b1;
    w_prev = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      w = bus.wr_ctrl;
      @(posedge clk);
      r = reset;
      #1;
      if (r) begin
        bus.wr_ctrl_rdy = 1'b1; cnt = 0; w_prev = 1'b0;
      end else begin
        if (stuck) begin
          bus.wr_ctrl_rdy = 1'b1; cnt = 0;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) bus.wr_ctrl_rdy = 1'b1;
        end else if (w && !w_prev) begin
          bus.wr_ctrl_rdy = 1'b0; cnt = 8;
        end
        w_prev = w;
      end
    end
  end

  // Compare process: every cycle out of reset, outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        e_wc = 0; e_pd = 0; e_full = 0; e_dr = 0; done_now = 0;
        if (phase == 1) begin
          if (prev_fit) begin
            phase = 2; iss = 0;
          end else begin
            cur_fit  = model_fits(m_wr_ptr, int'(bus.host_rd_ptr), m_len_w);
            e_full   = !cur_fit;
            prev_fit = cur_fit;
          end
        end
        if (phase == 2) begin
          iss++;
          if (stuck && iss > TMO) begin
            m_err_t = 1; phase = 3;
          end else if (!stuck && iss == HIGH + 1) begin
            e_pd = 1; done_now = 1; phase = 0;
            m_wr_ptr = n_wr_ptr; m_pkt_cnt++; m_wrap_cnt = n_wrap;
          end else begin
            e_wc = 1;
          end
        end
        if (phase == 0 && !done_now) e_dr = 1;
        chk1("wr_ctrl", bus.wr_ctrl, e_wc);
        chk1("desc_ready", bus.desc_ready, e_dr);
        chk1("full", full, e_full);
        chk1("pkt_done", pkt_done, e_pd);
        chk("wr_ptr", wr_ptr, m_wr_ptr);
        chk("pkt_cnt", pkt_cnt, m_pkt_cnt);
        chk("wrap_cnt", wrap_cnt, m_wrap_cnt);
        chk1("err_oversize", err_oversize, m_err_o);
        chk1("err_timeout", err_timeout, m_err_t);
        if (e_wc) begin
          chk("control", bus.control, x_ctrl);
          chk("pkt_end", bus.pkt_end, x_end);
          chk("write_address", bus.write_address, x_addr);
          chk("pkt_begin", bus.pkt_begin, 32'd0);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_wr_ptr = 0; m_pkt_cnt = 0; m_wrap_cnt = 0; m_len_w = 0;
    m_err_o = 0; m_err_t = 0; phase = 0; iss = 0; prev_fit = 0;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk1({tag, "_desc_ready"}, bus.desc_ready, 1'b1);
    chk1({tag, "_wr_ctrl"}, bus.wr_ctrl, 1'b0);
    chk({tag, "_wr_ptr"}, wr_ptr, 32'd0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
    chk({tag, "_write_address"}, bus.write_address, 32'd0);
    chk1({tag, "_err_oversize"}, err_oversize, 1'b0);
    chk1({tag, "_err_timeout"}, err_timeout, 1'b0);
    @(posedge clk);
    #1;
  endtask

  // One descriptor; optionally release a stall or reset mid-burst.
  task automatic send(input int len, input int release_after, input int release_rd, input bit abort);
    int lw, start;
    bit wrapped, done;
    lw = (len + 3) & ~3;
    if (len != 0 && len <= 2048) begin
      wrapped  = (m_wr_ptr + lw > RING);
      start    = wrapped ? 0 : m_wr_ptr;
      x_addr   = 32'h8000 + 32'(start);
      x_end    = 32'(lw);
      x_ctrl   = (32'(m_pkt_cnt & 'hFFFF) << 16) | 32'(len);
      n_wr_ptr = (start + lw) % RING;
      n_wrap   = m_wrap_cnt + (wrapped ? 1 : 0);
      m_len_w  = lw;
    end
    bus.desc_valid = 1'b1;
    bus.desc_len   = 16'(len);
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b0;
    if (len > 2048) m_err_o = 1;
    else if (len != 0) begin prev_fit = 0; phase = 1; end
    if (release_after > 0) begin
      repeat (release_after) @(negedge clk);
      chk1("stall_full", full, 1'b1);
      chk1("stall_wr_ctrl", bus.wr_ctrl, 1'b0);
      @(posedge clk);
      #1;
      bus.host_rd_ptr = 32'(release_rd);
    end
    if (abort) begin
      repeat (5) @(posedge clk);
      #1;
      do_reset();
      $display("txn len=%0d aborted by reset", len);
      return;
    end
    for (int i = 0; i < 300; i++) begin
      if (phase == 0 || phase == 3) break;
      @(negedge clk);
    end
    done = (phase == 0 || phase == 3);
    chk1("txn_done", done, 1'b1);
    @(posedge clk);
    #1;
    $display("txn len=%0d wr_ptr=%0d pkt_cnt=%0d wrap_cnt=%0d addr=%h end=%0d ctrl=%h",
             len, wr_ptr, pkt_cnt, wrap_cnt, bus.write_address, bus.pkt_end, bus.control);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached t=%0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    bus.desc_valid = 1'b0;
    bus.desc_len = '0;
    bus.host_rd_ptr = '0;
    stuck = 0;
    phase = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check_reset_state("rst");

    send(32, 0, 0, 0);
    chk("p1_write_address", bus.write_address, 32'h8000);
    chk("p1_pkt_end", bus.pkt_end, 32'd32);
    chk("p1_control", bus.control, 32'h0000_0020);
    chk("p1_wr_ptr", wr_ptr, 32'd32);
    chk("p1_pkt_cnt", pkt_cnt, 32'd1);

    send(30, 0, 0, 0);
    chk("p2_pkt_end", bus.pkt_end, 32'd32);
    chk("p2_control", bus.control, 32'h0001_001E);
    chk("p2_write_address", bus.write_address, 32'h8020);
    chk("p2_wr_ptr", wr_ptr, 32'd64);

    send(0, 0, 0, 0);
    chk("zero_pkt_cnt", pkt_cnt, 32'd2);
    chk("zero_wr_ptr", wr_ptr, 32'd64);

    send(3000, 0, 0, 0);
    chk1("oversize_flag", err_oversize, 1'b1);
    chk("oversize_pkt_cnt", pkt_cnt, 32'd2);

    for (int i = 0; i < 5; i++) send(32, 0, 0, 0);
    chk("fill_wr_ptr", wr_ptr, 32'd224);
    chk("fill_pkt_cnt", pkt_cnt, 32'd7);

    // Stall with host_rd_ptr=0, then free space by moving it to 128.
    send(64, 4, 128, 0);
    chk("wrap_write_address", bus.write_address, 32'h8000);
    chk("wrap_wr_ptr", wr_ptr, 32'd64);
    chk("wrap_cnt", wrap_cnt, 32'd1);
    chk("wrap_pkt_cnt", pkt_cnt, 32'd8);
    chk("wrap_control", bus.control, 32'h0007_0040);
    chk("wrap_pkt_end", bus.pkt_end, 32'd64);

    // Watchdog: wr_ctrl never acknowledged.
    stuck = 1;
    send(32, 0, 0, 0);
    chk1("tmo_err_timeout", err_timeout, 1'b1);
    chk1("tmo_wr_ctrl", bus.wr_ctrl, 1'b0);
    chk1("tmo_desc_ready", bus.desc_ready, 1'b0);
    bus.desc_valid = 1'b1;
    bus.desc_len = 16'd8;
    repeat (3) @(posedge clk);
    #1;
    bus.desc_valid = 1'b0;
    chk("tmo_pkt_cnt", pkt_cnt, 32'd8);
    stuck = 0;
    do_reset();
    check_reset_state("rst2");

    // Reset in the middle of a burst.
    bus.host_rd_ptr = '0;
    send(32, 0, 0, 1);
    check_reset_state("rst3");

    send(32, 0, 0, 0);
    chk("post_write_address", bus.write_address, 32'h8000);
    chk("post_wr_ptr", wr_ptr, 32'd32);
    chk("post_pkt_cnt", pkt_cnt, 32'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
